imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Takes a byte stream of the form  N_lo N_hi  {4 bytes per word} x N  [cksum]
// and turns it into 32-bit little-endian instruction-memory writes. Word k is
// written at BASE_ADDR + 4*k, and the address wraps modulo 2^20.
//
// Optional feature macro: IMEM_LOADER_CKSUM_EN
//    When defined, one checksum byte follows the data. If it does not equal the
//    XOR of all data bytes (0x00 when N=0), the sticky err flag is raised.
//    When undefined, the CKSUM state is never entered and err is tied to 0.
//
// Parameters
//    BASE_ADDR      byte address of the first loaded word (word-aligned)
//
// Ports
//    clk            single clock, rising edge
//    rst_n          asynchronous active-low reset
//    start          begins a session when sampled high in IDLE
//    in_valid       in_data is valid
//    in_data[7:0]   stream byte
//    in_ready       a byte transfers when in_valid && in_ready
//    wr_en          one-cycle word write strobe
//    wr_addr[19:0]  byte address of the written word
//    wr_data[31:0]  written word, byte at wr_addr in bits [7:0]
//    busy           high in every state except IDLE
//    done           one-cycle pulse at session end
//    err            sticky checksum error flag
//    words_written  words written in the current session
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter logic [19:0] BASE_ADDR = 20'h00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [19:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] words_written
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_CKSUM,
      S_DONE
   } state_t;

   // State that follows the last data word (or an empty length).
`ifdef IMEM_LOADER_CKSUM_EN
   localparam state_t S_END = S_CKSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  lane_q, lane_d;
   logic [19:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [15:0] words_q, words_d;

`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]  cksum_q, cksum_d;
   logic        err_q, err_d;
`endif

   // Next-state and output decode. Outputs depend only on the state register,
   // so an asynchronous reset drops in_ready/busy/done/wr_en immediately.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      lane_d   = lane_q;
      addr_d   = addr_q;
      data_d   = data_q;
      words_d  = words_q;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_d  = cksum_q;
      err_d    = err_q;
`endif
      in_ready = 1'b0;
      wr_en    = 1'b0;
      done     = 1'b0;
      busy     = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN0;
               words_d = 16'd0;
               addr_d  = BASE_ADDR;
               lane_d  = 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
               cksum_d = 8'h00;
               err_d   = 1'b0;
`endif
            end
         end

         S_LEN0: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d[7:0] = in_data;
               state_d    = S_LEN1;
            end
         end

         S_LEN1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d[15:8] = in_data;
               lane_d      = 2'd0;
               if ({in_data, len_q[7:0]} == 16'd0) begin
                  state_d = S_END;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         // Bytes fill lanes 0..3 in arrival order; the lane counter wraps
         // back to 0 on the 4th byte, ready for the next word.
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               case (lane_q)
                  2'd0:    data_d[7:0]   = in_data;
                  2'd1:    data_d[15:8]  = in_data;
                  2'd2:    data_d[23:16] = in_data;
                  default: data_d[31:24] = in_data;
               endcase
`ifdef IMEM_LOADER_CKSUM_EN
               cksum_d = cksum_q ^ in_data;
`endif
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         // wr_addr shows the current word address during the strobe; the
         // increment only becomes visible once the strobe is over.
         S_WRITE: begin
            wr_en   = 1'b1;
            words_d = words_q + 16'd1;
            addr_d  = addr_q + 20'd4;
            if (words_d < len_q) begin
               state_d = S_DATA;
            end else begin
               state_d = S_END;
            end
         end

         S_CKSUM: begin
            in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            if (in_valid) begin
               if (in_data != cksum_q) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
`else
            state_d = S_IDLE;
`endif
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         lane_q  <= 2'd0;
         addr_q  <= BASE_ADDR;
         data_q  <= 32'd0;
         words_q <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum_q <= 8'h00;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         words_q <= words_d;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum_q <= cksum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign wr_addr       = addr_q;
   assign wr_data       = data_q;
   assign words_written = words_q;

`ifdef IMEM_LOADER_CKSUM_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Two instances share the same stimulus:
// dut0 uses the default BASE_ADDR, dut1 uses 20'hFFFFC to exercise the
// address wrap. A negedge monitor records every write and done pulse.
// Builds with or without IMEM_LOADER_CKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        in_ready0, wr_en0, busy0, done0, err0;
   logic [19:0] wr_addr0;
   logic [31:0] wr_data0;
   logic [15:0] words0;

   logic        in_ready1, wr_en1, busy1, done1, err1;
   logic [19:0] wr_addr1;
   logic [31:0] wr_data1;
   logic [15:0] words1;

   int checks;
   int errors;

   logic [19:0] w0_addr[$];
   logic [31:0] w0_data[$];
   logic [19:0] w1_addr[$];
   logic [31:0] w1_data[$];
   int          done_cnt0;

   imem_loader #(.BASE_ADDR(20'h00000)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready0), .wr_en(wr_en0),
      .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0), .done(done0),
      .err(err0), .words_written(words0)
   );

   imem_loader #(.BASE_ADDR(20'hFFFFC)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready1), .wr_en(wr_en1),
      .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1), .done(done1),
      .err(err1), .words_written(words1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write/done monitor, sampled away from the active edge.
   initial done_cnt0 = 0;
   always @(negedge clk) begin
      if (wr_en0 === 1'b1) begin
         w0_addr.push_back(wr_addr0);
         w0_data.push_back(wr_data0);
      end
      if (wr_en1 === 1'b1) begin
         w1_addr.push_back(wr_addr1);
         w1_data.push_back(wr_data1);
      end
      if (done0 === 1'b1) done_cnt0 = done_cnt0 + 1;
   end

   task automatic pulse_start();
      in_valid = 1'b0;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   // Presents one byte after 'gap' idle cycles and holds it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready0 !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_byte timeout: in_ready=%b required 1", in_ready0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy0 !== 1'b0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_idle timeout: busy=%b required 0", busy0);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #23;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b required 0", busy0); end
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL reset in_ready: got %b required 0", in_ready0); end
      checks++; if (wr_en0 !== 1'b0) begin errors++; $display("[TB] FAIL reset wr_en: got %b required 0", wr_en0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b required 0", done0); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset err: got %b required 0", err0); end
      checks++; if (words0 !== 16'd0) begin errors++; $display("[TB] FAIL reset words_written: got %h required 0000", words0); end
      checks++; if (wr_data0 !== 32'd0) begin errors++; $display("[TB] FAIL reset wr_data: got %h required 00000000", wr_data0); end
      checks++; if (wr_addr0 !== 20'h00000) begin errors++; $display("[TB] FAIL reset wr_addr0: got %h required 00000", wr_addr0); end
      checks++; if (wr_addr1 !== 20'hFFFFC) begin errors++; $display("[TB] FAIL reset wr_addr1: got %h required FFFFC", wr_addr1); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_two_words();
      logic [7:0] d[8];
      int nw, nd;
      d = '{8'h13, 8'h02, 8'hA0, 8'h00, 8'h63, 8'h0C, 8'h00, 8'h02};
      nw = w0_addr.size();
      nd = done_cnt0;
      pulse_start();
      checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL two_words busy after start: got %b required 1", busy0); end
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 8; i++) begin
         send_byte(d[i], 0);
         if (i == 3 || i == 7) begin
            checks++;
            if (wr_en0 !== 1'b1) begin errors++; $display("[TB] FAIL two_words latency byte%0d: wr_en=%b required 1", i, wr_en0); end
         end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(8'hDC, 0);
`endif
      wait_idle();
      checks++;
      if (w0_addr.size() - nw !== 2) begin
         errors++; $display("[TB] FAIL two_words count: got %0d writes required 2", w0_addr.size() - nw);
      end else begin
         checks++; if (w0_addr[nw] !== 20'h00000) begin errors++; $display("[TB] FAIL two_words addr0: got %h required 00000", w0_addr[nw]); end
         checks++; if (w0_data[nw] !== 32'h00A00213) begin errors++; $display("[TB] FAIL two_words data0: got %h required 00A00213", w0_data[nw]); end
         checks++; if (w0_addr[nw+1] !== 20'h00004) begin errors++; $display("[TB] FAIL two_words addr1: got %h required 00004", w0_addr[nw+1]); end
         checks++; if (w0_data[nw+1] !== 32'h02000C63) begin errors++; $display("[TB] FAIL two_words data1: got %h required 02000C63", w0_data[nw+1]); end
      end
      checks++; if (words0 !== 16'd2) begin errors++; $display("[TB] FAIL two_words words_written: got %0d required 2", words0); end
      checks++; if (done_cnt0 - nd !== 1) begin errors++; $display("[TB] FAIL two_words done pulses: got %0d required 1", done_cnt0 - nd); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL two_words err: got %b required 0", err0); end
   endtask

   task automatic test_zero_len();
      int nw, nd;
      nw = w0_addr.size();
      nd = done_cnt0;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(8'h00, 0);
`endif
      wait_idle();
      checks++; if (w0_addr.size() - nw !== 0) begin errors++; $display("[TB] FAIL zero_len writes: got %0d required 0", w0_addr.size() - nw); end
      checks++; if (done_cnt0 - nd !== 1) begin errors++; $display("[TB] FAIL zero_len done pulses: got %0d required 1", done_cnt0 - nd); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL zero_len err: got %b required 0", err0); end
      checks++; if (words0 !== 16'd0) begin errors++; $display("[TB] FAIL zero_len words_written: got %0d required 0", words0); end
   endtask

`ifdef IMEM_LOADER_CKSUM_EN
   task automatic test_cksum_err();
      int nw;
      nw = w0_addr.size();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h45, 0);
      wait_idle();
      checks++;
      if (w0_addr.size() - nw !== 1) begin
         errors++; $display("[TB] FAIL cksum_err writes: got %0d required 1", w0_addr.size() - nw);
      end else begin
         checks++; if (w0_data[nw] !== 32'h44332211) begin errors++; $display("[TB] FAIL cksum_err data: got %h required 44332211", w0_data[nw]); end
      end
      checks++; if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL cksum_err err: got %b required 1", err0); end
      pulse_start();
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL cksum_err err after start: got %b required 0", err0); end
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      wait_idle();
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL cksum_err clean session err: got %b required 0", err0); end
   endtask
`endif

   task automatic test_addr_wrap();
      int nw;
      nw = w1_addr.size();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 0);
`endif
      wait_idle();
      checks++;
      if (w1_addr.size() - nw !== 2) begin
         errors++; $display("[TB] FAIL addr_wrap count: got %0d writes required 2", w1_addr.size() - nw);
      end else begin
         checks++; if (w1_addr[nw] !== 20'hFFFFC) begin errors++; $display("[TB] FAIL addr_wrap addr0: got %h required FFFFC", w1_addr[nw]); end
         checks++; if (w1_addr[nw+1] !== 20'h00000) begin errors++; $display("[TB] FAIL addr_wrap addr1: got %h required 00000", w1_addr[nw+1]); end
         checks++; if (w1_data[nw] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL addr_wrap data0: got %h required DEADBEEF", w1_data[nw]); end
         checks++; if (w1_data[nw+1] !== 32'h04030201) begin errors++; $display("[TB] FAIL addr_wrap data1: got %h required 04030201", w1_data[nw+1]); end
      end
   endtask

   task automatic test_reset_mid();
      int nw;
      nw = w0_addr.size();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h02, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid busy: got %b required 0", busy0); end
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid in_ready: got %b required 0", in_ready0); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid waits for start: busy=%b required 0", busy0); end
      checks++; if (w0_addr.size() - nw !== 0) begin errors++; $display("[TB] FAIL reset_mid writes: got %0d required 0", w0_addr.size() - nw); end
      test_two_words();
   endtask

   task automatic test_gaps_start();
      logic [7:0] d[8];
      int nw, nd;
      d = '{8'h13, 8'h02, 8'hA0, 8'h00, 8'h63, 8'h0C, 8'h00, 8'h02};
      nw = w0_addr.size();
      nd = done_cnt0;
      pulse_start();
      send_byte(8'h02, $urandom_range(0, 3));
      send_byte(8'h00, $urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
         send_byte(d[i], $urandom_range(0, 3));
         if (i == 1) pulse_start();
      end
`ifdef IMEM_LOADER_CKSUM_EN
      send_byte(8'hDC, $urandom_range(0, 3));
`endif
      wait_idle();
      checks++;
      if (w0_addr.size() - nw !== 2) begin
         errors++; $display("[TB] FAIL gaps count: got %0d writes required 2", w0_addr.size() - nw);
      end else begin
         checks++; if (w0_addr[nw] !== 20'h00000) begin errors++; $display("[TB] FAIL gaps addr0: got %h required 00000", w0_addr[nw]); end
         checks++; if (w0_data[nw] !== 32'h00A00213) begin errors++; $display("[TB] FAIL gaps data0: got %h required 00A00213", w0_data[nw]); end
         checks++; if (w0_addr[nw+1] !== 20'h00004) begin errors++; $display("[TB] FAIL gaps addr1: got %h required 00004", w0_addr[nw+1]); end
         checks++; if (w0_data[nw+1] !== 32'h02000C63) begin errors++; $display("[TB] FAIL gaps data1: got %h required 02000C63", w0_data[nw+1]); end
      end
      checks++; if (words0 !== 16'd2) begin errors++; $display("[TB] FAIL gaps words_written: got %0d required 2", words0); end
      checks++; if (done_cnt0 - nd !== 1) begin errors++; $display("[TB] FAIL gaps done pulses: got %0d required 1", done_cnt0 - nd); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_two_words();
      test_zero_len();
`ifdef IMEM_LOADER_CKSUM_EN
      test_cksum_err();
`endif
      test_addr_wrap();
      test_reset_mid();
      test_gaps_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
